// File: rtl/sec_encoder_pipe_pkg.sv
// ============================================================================
// Module : sec_pkg
// Brief  : Hamming(38,32) SEC code constants and check-bit helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sec_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CW_W   = 38;

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic logic [PAR_W-1:0] sec_pos(input int idx);
    logic [PAR_W-1:0] pos;
    int               cnt;
    pos = '0;
    cnt = 0;
    for (int p = 1; p <= CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = PAR_W'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [PAR_W-1:0] sec_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] par;
    logic [PAR_W-1:0] pos;
    par = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pos = sec_pos(i);
      for (int b = 0; b < PAR_W; b++) begin
        if (pos[b]) par[b] = par[b] ^ data[i];
      end
    end
    return par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_encoder_pipe_parity_gen.sv
// ============================================================================
// Module : sec_parity_gen
// Brief  : Combinational Hamming(38,32) check-bit generator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_parity_gen
  import sec_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [PAR_W-1:0]  parity_o
);

  assign parity_o = sec_parity(data_i);

endmodule

`default_nettype wire

// File: rtl/sec_encoder_pipe.sv
// ============================================================================
// Module : sec_encoder_pipe
// Brief  : 2-stage valid/ready SEC encoder with per-word error injection.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_encoder_pipe
  import sec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       in_data_i,
  input  logic [DATA_W+PAR_W-1:0] inj_mask_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [PAR_W-1:0]        out_parity_o,
  output logic [CNT_W-1:0]        word_count_o
);

  logic [PAR_W-1:0] w_parity;

  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]       s1_data_q,  s1_data_d;
  logic [PAR_W-1:0]        s1_par_q,   s1_par_d;
  logic [DATA_W+PAR_W-1:0] s1_mask_q,  s1_mask_d;

  logic                    s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]       s2_data_q,  s2_data_d;
  logic [PAR_W-1:0]        s2_par_q,   s2_par_d;

  logic [CNT_W-1:0]        count_q,    count_d;

  logic w_s2_free;
  logic w_in_fire;
  logic w_s1_adv;
  logic w_out_fire;

  sec_parity_gen u_parity_gen (
    .data_i   (in_data_i),
    .parity_o (w_parity)
  );

  assign w_s2_free  = !s2_valid_q || out_ready_i;
  // in_ready is held low during reset so nothing is accepted across release.
  assign in_ready_o = !rst && (!s1_valid_q || w_s2_free);
  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_s1_adv   = s1_valid_q && w_s2_free;
  assign w_out_fire = s2_valid_q && out_ready_i;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_par_d   = s1_par_q;
    s1_mask_d  = s1_mask_q;
    if (w_in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data_i;
      s1_par_d   = w_parity;
      s1_mask_d  = inj_mask_i;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // The mask is applied on the S1->S2 move so the outputs come straight from flops.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_par_d   = s2_par_q;
    if (w_s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q ^ s1_mask_q[DATA_W-1:0];
      s2_par_d   = s1_par_q ^ s1_mask_q[DATA_W+PAR_W-1:DATA_W];
    end else if (w_out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (w_out_fire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_par_q   <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_par_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_par_q   <= s1_par_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_par_q   <= s2_par_d;
      count_q    <= count_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign out_data_o   = s2_data_q;
  assign out_parity_o = s2_par_q;
  assign word_count_o = count_q;

endmodule

`default_nettype wire
